// File: rtl/rl_infer_sequencer_if.sv
// rl_infer_sequencer_if: request and action handshakes between the game FSM,
// the action consumer and the inference sequencer.
//   master : game FSM / consumer side (offers snapshots, accepts actions)
//   slave  : sequencer side
interface rl_infer_sequencer_if #(
  parameter int IN_DIM = 33
) ();

  // Request channel: one game-state snapshot per transfer.
  logic                   req_valid;
  logic                   req_ready;
  logic [IN_DIM-1:0][15:0] req_vec;

  // Action channel: one selected action per transfer.
  logic                   act_valid;
  logic                   act_ready;
  logic [3:0]             act_out;

  modport master (
    output req_valid, req_vec, act_ready,
    input  req_ready, act_valid, act_out
  );

  modport slave (
    input  req_valid, req_vec, act_ready,
    output req_ready, act_valid, act_out
  );

endinterface

// File: rtl/rl_infer_sequencer.sv
// rl_infer_sequencer: turn-level controller for the RL_model datapath.
// Freezes a game-state snapshot, pulses the datapath start, waits for done
// and hands the (range-checked) action to the consumer.
// Optional feature: define RL_SEQ_WATCHDOG_EN to build the WAIT watchdog that
// substitutes DEFAULT_ACTION after TIMEOUT_CYCLES cycles without done. With the
// macro undefined WAIT leaves only on infer_done or abort and timeout is 0.
module rl_infer_sequencer #(
  parameter int IN_DIM         = 33,
  parameter int NUM_ACTIONS    = 10,
  parameter int DEFAULT_ACTION = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    abort,
  rl_infer_sequencer_if.slave     bus,
  output logic [IN_DIM-1:0][15:0] infer_vec,
  output logic                    infer_start,
  input  logic                    infer_done,
  input  logic [3:0]              infer_action,
  output logic                    timeout,
  output logic                    bad_action,
  output logic                    busy,
  output logic [15:0]             infer_count
);

  localparam logic [4:0] NUM_ACT_L = 5'(NUM_ACTIONS);
  localparam logic [3:0] DEF_ACT   = 4'(DEFAULT_ACTION);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("rl_infer_sequencer: TIMEOUT_CYCLES must be at least 2");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t     state_q, state_d;
  logic       accept;
  logic       done_hit;
  logic       wd_expire;
  logic       action_legal;
  logic [3:0] act_out_q;
  logic       bad_q;

  // Abort blocks acceptance in the same cycle, so ready drops with it.
  assign bus.req_ready = (state_q == S_IDLE) && !abort;
  assign accept        = bus.req_valid && bus.req_ready;
  // infer_done only counts in WAIT; a stale level seen in START is discarded.
  assign done_hit      = (state_q == S_WAIT) && infer_done && !abort;
  assign action_legal  = {1'b0, infer_action} < NUM_ACT_L;

  assign bus.act_valid = (state_q == S_HOLD);
  assign bus.act_out   = act_out_q;
  assign infer_start   = (state_q == S_START);
  assign busy          = (state_q != S_IDLE);
  assign bad_action    = bad_q;

`ifdef RL_SEQ_WATCHDOG_EN
  localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             timeout_q;

  // Done has priority over expiry when both land in the same cycle.
  assign wd_expire = (state_q == S_WAIT) && !infer_done && !abort &&
                     (wd_cnt == WD_LAST);
  assign timeout   = timeout_q;

  // Watchdog counter: cleared on accept, advances once per WAIT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if ((state_q == S_WAIT) && !abort) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  // Sticky timeout flag: set on expiry, cleared by the next accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (accept) begin
      timeout_q <= 1'b0;
    end else if (wd_expire) begin
      timeout_q <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks, so every register
    // samples the values from before the edge regardless of block order.
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_d unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (accept) state_d = S_START;
        S_START: state_d = S_WAIT;
        S_WAIT:  if (done_hit || wd_expire) state_d = S_HOLD;
        S_HOLD:  if (bus.act_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Snapshot, action register, bad-action flag and inference counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the snapshot is reset even though it is wide, because it drives
      // the datapath input directly and must read as zeros out of reset.
      infer_vec   <= '0;
      act_out_q   <= '0;
      bad_q       <= 1'b0;
      infer_count <= '0;
    end else begin
      if (accept) begin
        infer_vec <= bus.req_vec;
        bad_q     <= 1'b0;
      end
      if (done_hit) begin
        act_out_q <= action_legal ? infer_action : DEF_ACT;
        bad_q     <= !action_legal;
        if (infer_count != 16'hFFFF) begin
          infer_count <= infer_count + 16'd1;
        end
      end else if (wd_expire) begin
        act_out_q <= DEF_ACT;
      end
    end
  end

endmodule

// File: tb/tb_rl_infer_sequencer.sv
// tb_rl_infer_sequencer: randomized scoreboard bench for rl_infer_sequencer.
// Stimulus pushes the expected action record when a request is accepted; an
// independent monitor pops and compares on every rising act_valid.
`timescale 1ns/1ps
module tb_rl_infer_sequencer;

  localparam int IN_DIM         = 33;
  localparam int NUM_ACTIONS    = 10;
  localparam int DEFAULT_ACTION = 0;
  localparam int TC             = 16;
`ifdef RL_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  typedef logic [IN_DIM-1:0][15:0] vec_t;
  typedef enum int {K_NORMAL, K_ABORT, K_RESET} kind_e;
  typedef struct {
    int          cycle;
    logic [3:0]  act;
    logic        tmo;
    logic        bad;
    logic [15:0] cnt;
    vec_t        vec;
  } exp_t;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic        abort        = 1'b0;
  logic        infer_done   = 1'b0;
  logic [3:0]  infer_action = 4'h0;
  vec_t        infer_vec;
  logic        infer_start;
  logic        timeout;
  logic        bad_action;
  logic        busy;
  logic [15:0] infer_count;

  rl_infer_sequencer_if #(.IN_DIM(IN_DIM)) bus ();

  rl_infer_sequencer #(
    .IN_DIM(IN_DIM),
    .NUM_ACTIONS(NUM_ACTIONS),
    .DEFAULT_ACTION(DEFAULT_ACTION),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .bus(bus),
    .infer_vec(infer_vec),
    .infer_start(infer_start),
    .infer_done(infer_done),
    .infer_action(infer_action),
    .timeout(timeout),
    .bad_action(bad_action),
    .busy(busy),
    .infer_count(infer_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  int   model_count = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < IN_DIM; i++) v[i] = 16'($urandom);
    return v;
  endfunction

  // Datapath model: a start pulse drops done, then done rises with the
  // programmed action dp_latency cycles later (0 = never). While reset is
  // held it presents a stale done so the sequencer must ignore it later.
  int         dp_latency = 0;
  logic [3:0] dp_action  = 4'h0;
  int         dp_left    = 0;
  bit         dp_armed   = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      dp_armed     = 1'b0;
      infer_done   = 1'b1;
      infer_action = 4'hF;
    end else if (infer_start) begin
      infer_done = 1'b0;
      dp_armed   = (dp_latency > 0);
      dp_left    = dp_latency;
    end else if (dp_armed) begin
      if (dp_left <= 1) begin
        infer_done   = 1'b1;
        infer_action = dp_action;
        dp_armed     = 1'b0;
      end else begin
        dp_left--;
      end
    end
  end

  // Monitor: every rising act_valid must match the oldest expectation.
  logic prev_valid = 1'b0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid <= 1'b0;
    end else begin
      if (bus.act_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("act_valid_unexpected", bus.act_valid, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          check("act_valid_cycle", cyc, mon_e.cycle);
          check("act_out", bus.act_out, mon_e.act);
          check("act_timeout", timeout, mon_e.tmo);
          check("act_bad_action", bad_action, mon_e.bad);
          check("act_infer_count", infer_count, mon_e.cnt);
          check("act_infer_vec", infer_vec == mon_e.vec, 1'b1);
        end
      end
      prev_valid <= bus.act_valid;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_act_valid"}, bus.act_valid, 1'b0);
    check({tag, "_infer_start"}, infer_start, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_act_out"}, bus.act_out, 4'h0);
    check({tag, "_timeout"}, timeout, 1'b0);
    check({tag, "_bad_action"}, bad_action, 1'b0);
    check({tag, "_infer_count"}, infer_count, 16'h0);
    check({tag, "_infer_vec_zero"}, infer_vec == '0, 1'b1);
  endtask

  // One request: accept, start pulse, then either a normal completion with a
  // consumer stall of `hold` cycles, or an abort/reset `kill` cycles into WAIT.
  task automatic run_req(input kind_e kind, input int lat, input logic [3:0] act,
                         input int hold, input int kill, input vec_t vec);
    int   t_acc;
    bit   got;
    bit   is_tmo;
    exp_t e;
    dp_latency = lat;
    dp_action  = act;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_vec   = vec;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready) got = 1'b1;
    end
    check("req_accept", got, 1'b1);
    if (!got) begin
      bus.req_valid = 1'b0;
      return;
    end
    t_acc  = cyc;
    is_tmo = WD && (lat == 0 || lat > TC);
    e.cycle = is_tmo ? t_acc + 2 + TC : t_acc + 2 + lat;
    e.act   = (is_tmo || act >= NUM_ACTIONS) ? 4'(DEFAULT_ACTION) : act;
    e.tmo   = is_tmo;
    e.bad   = !is_tmo && (act >= NUM_ACTIONS);
    if (kind == K_NORMAL && !is_tmo && model_count != 16'hFFFF) model_count++;
    e.cnt   = 16'(model_count);
    e.vec   = vec;
    if (kind == K_NORMAL) exp_q.push_back(e);

    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_vec   = rand_vec();
    @(negedge clk);
    check("start_pulse", infer_start, 1'b1);
    check("accept_clears_timeout", timeout, 1'b0);
    check("accept_clears_bad", bad_action, 1'b0);
    check("start_infer_vec", infer_vec == vec, 1'b1);
    @(negedge clk);
    check("start_drop", infer_start, 1'b0);

    if (kind == K_NORMAL) begin
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
        if (bus.act_valid) got = 1'b1;
        else @(negedge clk);
      end
      check("act_valid_seen", got, 1'b1);
      if (!got) return;
      for (int i = 0; i < hold; i++) begin
        check("hold_act_valid", bus.act_valid, 1'b1);
        check("hold_act_out", bus.act_out, e.act);
        check("hold_req_ready", bus.req_ready, 1'b0);
        check("hold_vec0", infer_vec[0], vec[0]);
        check("hold_infer_vec", infer_vec == vec, 1'b1);
        bus.req_vec = rand_vec();
        @(negedge clk);
      end
      bus.act_ready = 1'b1;
      @(posedge clk); #1;
      bus.act_ready = 1'b0;
      @(negedge clk);
      check("post_hs_req_ready", bus.req_ready, 1'b1);
      check("post_hs_act_valid", bus.act_valid, 1'b0);
      check("post_hs_busy", busy, 1'b0);
      check("post_hs_timeout", timeout, e.tmo);
      check("post_hs_bad_action", bad_action, e.bad);
      check("post_hs_count", infer_count, e.cnt);
    end else begin
      for (int i = 0; i < kill; i++) @(negedge clk);
      check("wait_busy", busy, 1'b1);
      check("wait_no_act", bus.act_valid, 1'b0);
      @(posedge clk); #1;
      if (kind == K_ABORT) begin
        abort         = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_vec   = rand_vec();
        @(negedge clk);
        check("abort_req_ready", bus.req_ready, 1'b0);
        @(posedge clk); #1;
        abort         = 1'b0;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_idle", busy, 1'b0);
        check("abort_act_valid", bus.act_valid, 1'b0);
        check("abort_req_ready_after", bus.req_ready, 1'b1);
        check("abort_vec_kept", infer_vec == vec, 1'b1);
        check("abort_count_kept", infer_count, 16'(model_count));
      end else begin
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrun_reset");
        model_count = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_release_ready", bus.req_ready, 1'b1);
        check("reset_release_act", bus.act_valid, 1'b0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL sim_time_limit: run still active, required to finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    vec_t v;
    int   r;
    int   lat;
    bus.req_valid = 1'b0;
    bus.req_vec   = '0;
    bus.act_ready = 1'b0;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1'b1);

    // Basic request: word 0 = 0x0400, done 50 cycles after start, action 3,
    // consumer stalls 20 cycles.
    v = rand_vec();
    v[0] = 16'h0400;
    run_req(K_NORMAL, 50, 4'd3, 20, 0, v);
    // Illegal action -> default plus bad_action; next accept clears it.
    run_req(K_NORMAL, 5, 4'd12, 2, 0, rand_vec());
    run_req(K_NORMAL, 1, 4'd9, 0, 0, rand_vec());
`ifdef RL_SEQ_WATCHDOG_EN
    run_req(K_NORMAL, 0, 4'd5, 2, 0, rand_vec());
`else
    run_req(K_ABORT, 0, 4'd5, 0, 40, rand_vec());
`endif
    // Done exactly in the expiry cycle, then one cycle too late.
    run_req(K_NORMAL, 16, 4'd7, 1, 0, rand_vec());
    run_req(K_NORMAL, 17, 4'd2, 1, 0, rand_vec());
    // Abort together with req_valid in WAIT, then a normal request.
    run_req(K_ABORT, 30, 4'd4, 0, 3, rand_vec());
    run_req(K_NORMAL, 8, 4'd6, 1, 0, rand_vec());
    // Reset mid-WAIT, stale done after release, then a normal request.
    run_req(K_RESET, 30, 4'd1, 0, 5, rand_vec());
    run_req(K_NORMAL, 10, 4'd8, 3, 0, rand_vec());

    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7) begin
        lat = int'($urandom_range(1, 30));
        if (WD && $urandom_range(0, 5) == 0) lat = 0;
        run_req(K_NORMAL, lat, 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 4)), 0, rand_vec());
      end else begin
        run_req((r < 9) ? K_ABORT : K_RESET, int'($urandom_range(12, 30)),
                4'($urandom_range(0, 15)), 0, int'($urandom_range(0, 8)), rand_vec());
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rl_infer_sequencer.md
# rl_infer_sequencer

Turn-level controller for the RL policy datapath: `RL_model` (MLP inference plus mask/argmax). It accepts a game-state snapshot from the game FSM over a valid/ready handshake and freezes it into a register so the datapath input stays stable for the whole inference. It then pulses the datapath start, waits for inference-done, and returns the selected action over a second valid/ready handshake. A watchdog substitutes a default action if the datapath stalls.

## Interface
- `IN_DIM`, 33: number of signed 16-bit state words.
- `NUM_ACTIONS`, 10: legal action codes are 0..NUM_ACTIONS-1.
- `DEFAULT_ACTION`, 0: code substituted on timeout or an illegal action.
- `TIMEOUT_CYCLES`, 4096: maximum WAIT cycles before the watchdog fires. Must be ≥2.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `abort` in 1: synchronous abort; highest priority after reset.
- `req_valid` in 1: the game FSM offers a state snapshot.
- `req_ready` out 1: high only in IDLE.
- `req_vec` in 16×IN_DIM: signed state words, sampled on req_valid&&req_ready.
- `infer_vec` out 16×IN_DIM: frozen snapshot that drives the datapath `in_vec`.
- `infer_start` out 1: one-cycle start pulse to the datapath.
- `infer_done` in 1: datapath done level.
- `infer_action` in 4: masked argmax output from the datapath.
- `act_valid` out 1: action available.
- `act_ready` in 1: the consumer accepts the action.
- `act_out` out 4: registered action.
- `timeout` out 1: last action came from the watchdog. Sticky until the next accepted request.
- `bad_action` out 1: last datapath action was ≥NUM_ACTIONS. Sticky until the next accepted request.
- `busy` out 1: high whenever the state is not IDLE.
- `infer_count` out 16: number of completed inferences; saturates at 0xFFFF.

## Operation
- FSM states and transitions:
  - IDLE → START when req_valid&&req_ready.
  - START → WAIT unconditionally.
  - WAIT → HOLD on infer_done or watchdog expiry.
  - HOLD → IDLE on act_valid&&act_ready.
- Request accept:
  - `infer_vec` ← `req_vec`.
  - `timeout` and `bad_action` are cleared.
  - Watchdog counter is cleared.
  - `infer_vec` is written only on an accept. It holds its value through START, WAIT and HOLD.
- START: `infer_start`=1 for exactly this one cycle. `infer_done` is ignored in START, so a stale done from the previous run is discarded. The datapath deasserts done within one cycle of start.
- WAIT: the watchdog counter increments every cycle.
  - If `infer_done`=1: `act_out` ← `infer_action` if it is <NUM_ACTIONS. Otherwise `act_out` ← DEFAULT_ACTION and `bad_action` ← 1. `infer_count` increments (saturating).
  - If the counter reaches TIMEOUT_CYCLES-1 without done: `act_out` ← DEFAULT_ACTION and `timeout` ← 1. `infer_count` is unchanged.
  - If done and expiry occur in the same cycle, done wins.
- HOLD: `act_valid`=1. `act_out` is stable until the handshake completes.
- `abort`: go to IDLE next cycle from any state.
  - `act_valid` and `infer_start` drop.
  - `infer_vec`, the sticky flags and `infer_count` are retained.
  - A req_valid in the same cycle is not accepted.
- Reset values: state IDLE, `req_ready`=1 after reset release, all other outputs 0, `infer_vec` all zeros.

## Timing
- Accept in cycle T.
- `infer_start` is high in cycle T+1 (START).
- WAIT begins at T+2.
- If `infer_done` is first seen high in WAIT cycle D, `act_valid` goes high in D+1.
- Minimum request-to-action latency is 3 cycles.
- Handshake: act_valid&&act_ready in cycle H gives IDLE and `req_ready`=1 at H+1. There is no same-cycle turnaround; a new request is accepted no earlier than H+1.
- Timeout path: with no done, `act_valid` rises at T+2+TIMEOUT_CYCLES.
- Reset asserted mid-operation: all state is cleared immediately (asynchronous), with no start pulse and no action emitted.

## Configuration
- `RL_SEQ_WATCHDOG_EN` defined: watchdog counter and `timeout` behave as specified above.
- Macro undefined:
  - No counter is synthesized.
  - WAIT exits only on `infer_done` or `abort`.
  - `timeout` is tied to 0.
  - TIMEOUT_CYCLES is unused.

## Test plan
- Reset then a single request with req_vec[0]=0x0400 and datapath done 50 cycles after start with action 3. Required:
  - `infer_start` is a 1-cycle pulse at T+1.
  - `infer_vec[0]`=0x0400 throughout.
  - `act_out`=3 and `act_valid` at D+1.
  - `infer_count`=1.
- Consumer holds act_ready=0 for 20 cycles. Required: `act_valid` and `act_out` are stable, `req_ready`=0, and req_vec changes do not alter `infer_vec`.
- Datapath returns action 12. Required: `act_out`=DEFAULT_ACTION and `bad_action`=1. The flag clears on the next accept.
- Watchdog build with TIMEOUT_CYCLES=16 and no done. Required:
  - `act_valid` at T+18.
  - `timeout`=1 and `act_out`=0.
  - `infer_count` unchanged.
  - Done arriving in the expiry cycle gives the datapath action instead, with `timeout`=0.
- `abort` asserted in WAIT together with req_valid. Required: IDLE next cycle, no acceptance that cycle, and no `act_valid`. A following request completes normally.
- `rst_n` pulsed low mid-WAIT. Required: all outputs 0 asynchronously, `infer_vec` zeros, and a stale done after release is ignored.
